// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// The ALUCTL_* codes are also used by the ALU decoder.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [3:0] ALUCTL_MULT = 4'b1000;
    localparam logic [3:0] ALUCTL_DIV  = 4'b1001;

    // One product or quotient bit is produced per CALC cycle.
    localparam int ITERS = 32;
    localparam int CNT_W = 5;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negation.
// It is used two ways. To extract a magnitude, drive neg_i with the operand's
// sign bit. To apply the recorded result sign in the FIX step, drive neg_i with
// that sign.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    // Negate when requested; otherwise pass the value through.
    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed MULT/DIV unit. It owns the HI/LO registers.
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, MULT is a
// single-cycle signed multiply that writes HI/LO on the start edge.
//
// Handshake: a request is "valid" when en & hien & loen is high and alucontrol
// is MULT or DIV. It is accepted only on an edge where busy is low and flush is
// low. While busy is high, requests are dropped, not queued; the pipeline must
// stall on busy. busy is a decode of the state register only.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [3:0]       alucontrol,
    input  logic             hien,
    input  logic             loen,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int W = WIDTH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;     // product sign or quotient sign
    logic             rsign_q, rsign_d;   // remainder sign (dividend sign)
    logic [W-1:0]     dvs_q, dvs_d;       // multiplicand or divisor magnitude
    logic [2*W-1:0]   acc_q, acc_d;       // {acc/remainder, multiplier/quotient}
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    logic             start_ok, start_mul, start_div, start_iter;
    logic [W-1:0]     a_mag, b_mag;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next, div_next;
    logic [W:0]       rem_sh, trial;
    logic [W-1:0]     rem_new;
    logic [2*W-1:0]   prod_fixed;
    logic [W-1:0]     quo_fixed, rem_fixed;

    assign start_ok  = en & hien & loen & ~flush & (state_q == IDLE);
    assign start_mul = start_ok & (alucontrol == ALUCTL_MULT);
    assign start_div = start_ok & (alucontrol == ALUCTL_DIV);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*W-1:0] fast_prod;
    assign fast_prod  = $signed(srca) * $signed(srcb);
    assign start_iter = start_div;
`else
    assign start_iter = start_mul | start_div;
`endif

    // Operand magnitudes are captured on the start edge.
    muldiv_signfix #(.W(W)) u_mag_a (.val_i(srca), .neg_i(srca[W-1]), .val_o(a_mag));
    muldiv_signfix #(.W(W)) u_mag_b (.val_i(srcb), .neg_i(srcb[W-1]), .val_o(b_mag));

    // Sign fix-up in FIX. A zero divisor leaves the quotient at all ones. The
    // remainder then equals |srca|, and the remainder-sign negate restores srca.
    muldiv_signfix #(.W(2*W)) u_fix_p (.val_i(acc_q), .neg_i(sign_q), .val_o(prod_fixed));
    muldiv_signfix #(.W(W)) u_fix_q (.val_i(acc_q[W-1:0]), .neg_i(sign_q & (|dvs_q)),
                                     .val_o(quo_fixed));
    muldiv_signfix #(.W(W)) u_fix_r (.val_i(acc_q[2*W-1:W]), .neg_i(rsign_q),
                                     .val_o(rem_fixed));

    // One shift-add multiply step and one restoring-divide step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? dvs_q : {W{1'b0}})};
        mul_next = {mul_sum, acc_q[W-1:1]};
        rem_sh   = acc_q[2*W-1:W-1];
        trial    = rem_sh - {1'b0, dvs_q};
        rem_new  = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        div_next = {rem_new, acc_q[W-2:0], ~trial[W]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        dvs_d    = dvs_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start_iter) begin
                    state_d  = CALC;
                    cnt_d    = CNT_W'(ITERS - 1);
                    is_div_d = start_div;
                    sign_d   = srca[W-1] ^ srcb[W-1];
                    rsign_d  = srca[W-1];
                    if (start_div) begin
                        dvs_d = b_mag;
                        acc_d = {{W{1'b0}}, a_mag};
                    end else begin
                        dvs_d = a_mag;
                        acc_d = {{W{1'b0}}, b_mag};
                    end
                end
`ifdef MULDIV_FAST_MUL_EN
                if (start_mul) begin
                    hi_d = fast_prod[2*W-1:W];
                    lo_d = fast_prod[W-1:0];
                end
`endif
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = is_div_q ? rem_fixed : prod_fixed[2*W-1:W];
                    lo_d = is_div_q ? quo_fixed : prod_fixed[W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            dvs_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            dvs_q    <= dvs_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
